spi_wb_master: RTL
==================

Name: spi_wb_master

Overview:
- Wishbone master stage directly downstream of the SPI slave.
- Takes the decoded SPI transaction (wrn, select, address, data, start) and synchronises start into the system clock domain.
- Runs one classic single Wishbone cycle per start and returns read data on read_data, which drives the SPI slave's write_data input.
- Sits between the SPI slave and the system Wishbone interconnect.

Parameters:
- ADDR_WIDTH, 19, width of address input and wb_adr_o.
- DATA_WIDTH, 32, Wishbone data width; only 32 supported.
- TIMEOUT_CYCLES, 255, wb_clk_i cycles allowed in WAIT_ACK before abort; used only with the optional feature.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- start  in  1  transaction request from SPI slave, sclk domain, asynchronous here
- wrn  in  1  1=write, 0=read; quasi-static when start rises
- select  in  4  byte-lane code using the WB_* macros from system_includes.vh
- address  in  ADDR_WIDTH  byte address; quasi-static
- data  in  DATA_WIDTH  write data, already lane-aligned; quasi-static
- read_data  out  DATA_WIDTH  last read word, raw lane positions, to SPI slave write_data
- busy  out  1  high from detect through DONE
- done  out  1  one-cycle pulse when a cycle completes
- overrun  out  1  sticky; start edge seen while busy
- wb_adr_o  out  ADDR_WIDTH
- wb_dat_o  out  DATA_WIDTH
- wb_sel_o  out  4
- wb_we_o  out  1
- wb_cyc_o  out  1
- wb_stb_o  out  1
- wb_dat_i  in  DATA_WIDTH
- wb_ack_i  in  1
- wb_err_i  in  1
- wb_err_o  out  1  one-cycle pulse on bus error or timeout

Behaviour:
- Reset values: all outputs 0, read_data 0, FSM in IDLE, synchroniser flops 0.
- Reset mid-cycle drops cyc/stb on the next edge; no done pulse.
- Start synchroniser:
  - start_meta -> start_sync -> start_d; start_pulse = start_sync & ~start_d.
  - sclk must be at most wb_clk_i/4 so each start high is sampled at least twice.
- Capture:
  - On start_pulse in IDLE, register wrn, select, address and data.
  - The FSM goes to REQ and busy rises the same edge.
- REQ (1 cycle):
  - Assert cyc/stb and drive we = wrn, sel = select, adr = address, dat_o = data.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - Hold all bus outputs stable.
  - On wb_ack_i: drop cyc/stb next edge; if read, read_data <= wb_dat_i; go to DONE.
  - On wb_err_i (priority over ack when both are high): drop cyc/stb, read_data unchanged, pulse wb_err_o, go to DONE.
- DONE (1 cycle): pulse done, then go to IDLE with busy low.
- Latency:
  - start rising -> wb_cyc_o high: 4 wb_clk_i edges (3 sync/detect + REQ register).
  - Zero-wait slave: ack -> done pulse 2 edges later.
- Overrun:
  - A start_pulse outside IDLE is ignored and sets overrun.
  - overrun clears only on reset.
- Writes never modify read_data.
- select is forwarded unchanged to wb_sel_o; no lane shifting.
- Illegal select codes are passed through; no decode errors are raised.
- wb_dat_o is driven 0 on reads.

Optional Feature:
- Macro: SPI_WB_TIMEOUT_EN.
- With the macro: an 8..16-bit counter clears on REQ and increments each WAIT_ACK cycle.
  - At TIMEOUT_CYCLES with no ack/err: drop cyc/stb, set read_data <= 32'hDEAD_BEEF on reads, pulse wb_err_o, go to DONE.
- Without the macro: no counter; WAIT_ACK waits forever. Reset is the only escape.

Decomposition:
- Package spi_wb_pkg holds:
  - the state typedef (IDLE, REQ, WAIT_ACK, DONE);
  - the timeout fill constant 32'hDEAD_BEEF.
- Select codes remain the shared WB_* macros.
- One sub-module, spi_wb_pulse_sync: 2-flop synchroniser plus rising-edge detector, reusable for other sclk->wb_clk_i strobes.

Test Plan:
- Write full word: wrn=1, select=WB_FULL_WORD, address=19'h00100, data=32'hA5A5_1234, start high 4 sclk; ack after 2 waits -> cyc 4 edges after start; adr/dat/sel=4'hF/we=1 stable until ack; one done pulse; read_data stays 0.
- Byte read: wrn=0, select=WB_BYTE_1, address=19'h7FFFF; slave returns 32'h1122_3344 -> wb_sel_o=WB_BYTE_1, read_data=32'h1122_3344 after ack, we=0, dat_o=0.
- Back-to-back: two reads separated by 12 idle wb_clk_i cycles -> two full cycles, two done pulses, read_data holds the second value, overrun=0.
- Overrun: second start edge during WAIT_ACK (ack delayed 20 cycles) -> only one Wishbone cycle, overrun=1 sticky until reset.
- Error/timeout (SPI_WB_TIMEOUT_EN):
  - slave asserts err -> wb_err_o pulse, done, read_data unchanged;
  - slave silent -> after 255 WAIT_ACK cycles cyc drops, read_data=32'hDEAD_BEEF.
- Reset mid-cycle: assert wb_rst_i during WAIT_ACK -> cyc/stb/busy low next edge, no done; a following transaction completes normally.

Source files
------------

// File: rtl/spi_wb_pkg.sv
// Shared types and constants for the SPI-to-Wishbone master stage.
package spi_wb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        DONE     = 2'd3
    } wb_state_e;

    // Returned as read data when a read is abandoned by the ack timeout.
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/spi_wb_pulse_sync.sv
// Two-flop synchroniser plus rising-edge detector for strobes arriving from
// the sclk domain; pulse_o is one clk cycle wide per input rising edge.
module spi_wb_pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic in_async,
    output logic pulse_o
);

    logic meta_q, sync_q, dly_q;
    logic meta_d, sync_d, dly_d;

    always_comb begin
        meta_d = in_async;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign pulse_o = sync_q & ~dly_q;

endmodule

// File: rtl/spi_wb_master.sv
// Wishbone master driven by decoded SPI transactions: one classic single cycle
// per start edge. Define SPI_WB_TIMEOUT_EN to abort cycles the slave never answers.
module spi_wb_master
    import spi_wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 19,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start,
    input  logic                  wrn,
    input  logic [3:0]            select,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    output logic                  wb_err_o
);

    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
        $error("spi_wb_master: DATA_WIDTH must be 32 and TIMEOUT_CYCLES 1..65535");
    end

    logic start_pulse;

    spi_wb_pulse_sync u_start_sync (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .in_async (start),
        .pulse_o  (start_pulse)
    );

    wb_state_e             state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [3:0]            sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef SPI_WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        overrun_d = overrun_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rdata_d   = rdata_q;
`ifdef SPI_WB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        if (start_pulse && state_q != IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Request fields are captured straight into the bus registers,
                // so they are already stable when cyc/stb rise.
                if (start_pulse) begin
                    we_d    = wrn;
                    sel_d   = select;
                    adr_d   = address;
                    dat_d   = wrn ? data : '0;
                    busy_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                cyc_d   = 1'b1;
                state_d = WAIT_ACK;
`ifdef SPI_WB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_ACK: begin
                if (wb_err_i) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = wb_dat_i;
                    end
                    state_d = DONE;
`ifdef SPI_WB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = DATA_WIDTH'(TIMEOUT_FILL);
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
`ifdef SPI_WB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rdata_q   <= rdata_d;
`ifdef SPI_WB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign read_data = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign wb_we_o   = we_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_err_o  = err_q;

endmodule
